// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl_pkg
//  Description : Shared memory-op codes, FSM state encoding, bus size codes
//                and small decode helpers for the data-memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

  // Memory operation codes carried by memop_i
  localparam logic [3:0] MEMOP_LB  = 4'd0;
  localparam logic [3:0] MEMOP_LBU = 4'd1;
  localparam logic [3:0] MEMOP_LH  = 4'd2;
  localparam logic [3:0] MEMOP_LHU = 4'd3;
  localparam logic [3:0] MEMOP_LW  = 4'd4;
  localparam logic [3:0] MEMOP_SB  = 4'd5;
  localparam logic [3:0] MEMOP_SH  = 4'd6;
  localparam logic [3:0] MEMOP_SW  = 4'd7;

  // Bus transfer size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Transfer size implied by an op; unknown codes are treated as words
  function automatic logic [1:0] memopSize(input logic [3:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: memopSize = SIZE_BYTE;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: memopSize = SIZE_HALF;
      default:                       memopSize = SIZE_WORD;
    endcase
  endfunction

  function automatic logic memopIsStore(input logic [3:0] op);
    memopIsStore = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  // Address low bits do not match the natural alignment of the op
  function automatic logic memopMisaligned(input logic [3:0] op, input logic [1:0] addrLo);
    case (memopSize(op))
      SIZE_HALF: memopMisaligned = addrLo[0];
      SIZE_WORD: memopMisaligned = (addrLo != 2'b00);
      default:   memopMisaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_lane_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_fmt
//  Description : Combinational little-endian lane formatter. Builds byte
//                strobes, bus size and replicated store data, and extracts
//                and extends load data from the returned bus word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
  import dmem_access_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic [31:0] wdataRep,
  output logic [31:0] rdataExt
);

  logic [31:0] w_rdShift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_rdShift = rdata >> {addrLo, 3'b000};
  assign w_byte    = w_rdShift[7:0];
  assign w_half    = addrLo[1] ? rdata[31:16] : rdata[15:0];

  // Store side: strobes and lane replication
  always_comb begin
    wstrb    = 4'b0000;
    wdataRep = 32'h0;
    size     = memopSize(op);
    case (op)
      MEMOP_SB: begin
        wstrb    = 4'b0001 << addrLo;
        wdataRep = {4{wdata[7:0]}};
      end
      MEMOP_SH: begin
        wstrb    = addrLo[1] ? 4'b1100 : 4'b0011;
        wdataRep = {2{wdata[15:0]}};
      end
      MEMOP_SW: begin
        wstrb    = 4'b1111;
        wdataRep = wdata;
      end
      default: begin
        wstrb    = 4'b0000;
        wdataRep = 32'h0;
      end
    endcase
  end

  // Load side: lane select and sign/zero extension
  always_comb begin
    rdataExt = rdata;
    case (op)
      MEMOP_LB:  rdataExt = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: rdataExt = {24'h0, w_byte};
      MEMOP_LH:  rdataExt = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: rdataExt = {16'h0, w_half};
      default:   rdataExt = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : M-stage data-memory access controller. Issues one SRAM-like
//                bus transaction (req/addr_ok/data_ok) per load/store, stalls
//                the pipeline until it completes and returns extended load
//                data. A flush during an access lets the bus transfer finish
//                but discards its result.
//  Config      : DMEM_ALIGN_CHECK_EN - when defined, misaligned accesses raise
//                adel_o/ades_o and are not issued; when undefined the address
//                low bits are forced to natural alignment and errors are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en_i,
  input  logic [3:0]        memop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  input  logic              pipe_stall_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_cancel;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_misaligned;
  logic [ADDR_W-1:0] w_addrNat;
  logic              w_start;
  logic              w_capture;
  logic [DATA_W-1:0] w_rdataExt;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misaligned = memopMisaligned(memop_i, addr_i[1:0]);
  assign w_addrNat    = addr_i;
`else
  assign w_misaligned = 1'b0;
  // Without checking, snap the address down to the op's natural boundary
  always_comb begin
    w_addrNat = addr_i;
    case (memopSize(memop_i))
      SIZE_HALF: w_addrNat = {addr_i[ADDR_W-1:1], 1'b0};
      SIZE_WORD: w_addrNat = {addr_i[ADDR_W-1:2], 2'b00};
      default:   w_addrNat = addr_i;
    endcase
  end
`endif

  assign adel_o  = mem_en_i & w_misaligned & ~memopIsStore(memop_i);
  assign ades_o  = mem_en_i & w_misaligned &  memopIsStore(memop_i);

  // A new access may launch only out of reset, aligned and not being killed
  assign w_start = resetn & mem_en_i & ~w_misaligned & ~flush_i;

  // Bus fields come from the latched request so they stay stable in REQ
  assign data_wr    = memopIsStore(r_op);
  assign data_addr  = r_addr;
  assign rdata_o    = r_rdata;

  mem_lane_fmt u_laneFmt (
    .op       (r_op),
    .addrLo   (r_addr[1:0]),
    .wdata    (r_wdata),
    .rdata    (data_rdata),
    .wstrb    (data_wstrb),
    .size     (data_size),
    .wdataRep (data_wdata),
    .rdataExt (w_rdataExt)
  );

  // Next-state, stall, request and result-capture decode
  always_comb begin
    w_nextState = r_state;
    stall_o     = 1'b0;
    data_req    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          stall_o     = 1'b1;
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        // Request is held until accepted, even when flushed
        stall_o  = 1'b1;
        data_req = 1'b1;
        if (data_addr_ok) w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (data_data_ok) begin
          if (r_cancel || flush_i) begin
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_DONE;
            // Store completions leave the previous load result in place
            w_capture   = ~memopIsStore(r_op);
          end
        end
      end
      ST_DONE: begin
        if (!pipe_stall_i || flush_i) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, request latch, cancel flag and load result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cancel <= 1'b0;
      r_op     <= MEMOP_LB;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && w_start) begin
        r_op    <= memop_i;
        r_addr  <= w_addrNat;
        r_wdata <= wdata_i;
      end
      if (w_nextState == ST_IDLE) begin
        r_cancel <= 1'b0;
      end else if ((r_state == ST_REQ || r_state == ST_WAIT) && flush_i) begin
        r_cancel <= 1'b1;
      end
      if (w_capture) r_rdata <= w_rdataExt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_ctrl
//  Description : Self-checking bench for dmem_access_ctrl with a bus
//                responder of programmable latency and a transaction-level
//                reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_en_i = 1'b0;
  logic [3:0]  memop_i = MEMOP_LB;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        pipe_stall_i = 1'b0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        adel_o;
  logic        ades_o;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .mem_en_i(mem_en_i), .memop_i(memop_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
    .pipe_stall_i(pipe_stall_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .adel_o(adel_o), .ades_o(ades_o), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- specification-level reference rules ----------------
  function automatic int szOf(input logic [3:0] op);
    if (op == MEMOP_LB || op == MEMOP_LBU || op == MEMOP_SB) return 0;
    if (op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) return 1;
    return 2;
  endfunction

  function automatic bit isSt(input logic [3:0] op);
    return op == MEMOP_SB || op == MEMOP_SH || op == MEMOP_SW;
  endfunction

  function automatic bit misal(input logic [3:0] op, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (szOf(op) == 1 && a % 2 != 0) || (szOf(op) == 2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] natAddr(input logic [3:0] op, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a;
`else
    if (szOf(op) == 1) return a - (a % 2);
    if (szOf(op) == 2) return a - (a % 4);
    return a;
`endif
  endfunction

  function automatic logic [3:0] expStrb(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (op == MEMOP_SB) s = 4'(1 << (a % 4));
    if (op == MEMOP_SH) s = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    if (op == MEMOP_SW) s = 4'b1111;
    return s;
  endfunction

  function automatic logic [31:0] expWdata(input logic [3:0] op, input logic [31:0] w);
    logic [31:0] b, h;
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    if (op == MEMOP_SB) return b * 32'h0101_0101;
    if (op == MEMOP_SH) return h * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] expLoad(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * (a % 4))) & 32'hFF;
    h = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (op)
      MEMOP_LB:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      MEMOP_LBU: return b;
      MEMOP_LH:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      MEMOP_LHU: return h;
      default:   return r;
    endcase
  endfunction

  // ---------------- transaction-level model ----------------
  bit          mReq, mResp, mHold, mCancel;
  logic [3:0]  mOp;
  logic [31:0] mAddr, mWdata, mRdata;

  // Track the outstanding access: awaiting accept, awaiting response, result held
  always @(posedge clk) begin
    if (!resetn) begin
      mReq <= 0; mResp <= 0; mHold <= 0; mCancel <= 0;
      mOp <= MEMOP_LB; mAddr <= 0; mWdata <= 0; mRdata <= 0;
    end else if (mReq) begin
      if (flush_i) mCancel <= 1;
      if (data_addr_ok) begin mReq <= 0; mResp <= 1; end
    end else if (mResp) begin
      if (flush_i) mCancel <= 1;
      if (data_data_ok) begin
        mResp   <= 0;
        mCancel <= 0;
        if (!(mCancel || flush_i)) begin
          mHold <= 1;
          if (!isSt(mOp)) mRdata <= expLoad(mOp, mAddr, data_rdata);
        end
      end
    end else if (mHold) begin
      if (!pipe_stall_i || flush_i) mHold <= 0;
    end else if (mem_en_i && !misal(memop_i, addr_i) && !flush_i) begin
      mReq   <= 1;
      mOp    <= memop_i;
      mAddr  <= natAddr(memop_i, addr_i);
      mWdata <= wdata_i;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit expStall, mis;
    mis = misal(memop_i, addr_i);
    expStall = mReq || mResp ||
               (!mHold && resetn && mem_en_i && !mis && !flush_i);
    check("stall_o", {31'b0, stall_o}, {31'b0, expStall});
    check("data_req", {31'b0, data_req}, {31'b0, mReq});
    check("rdata_o", rdata_o, mRdata);
    check("adel_o", {31'b0, adel_o}, {31'b0, mem_en_i && mis && !isSt(memop_i)});
    check("ades_o", {31'b0, ades_o}, {31'b0, mem_en_i && mis && isSt(memop_i)});
    if (mReq) begin
      check("data_addr", data_addr, mAddr);
      check("data_wr", {31'b0, data_wr}, {31'b0, isSt(mOp)});
      check("data_size", {30'b0, data_size}, 32'(szOf(mOp)));
      check("data_wstrb", {28'b0, data_wstrb}, {28'b0, expStrb(mOp, mAddr)});
      if (isSt(mOp)) check("data_wdata", data_wdata, expWdata(mOp, mWdata));
    end
  end

  // ---------------- bus responder ----------------
  int          addrLat = 1, dataLat = 1;
  logic [31:0] rdVal = 32'h0;
  bit          pendResp, prevAok, rstSeen;
  int          reqCnt, respCnt;

  // Accept after addrLat request cycles, respond dataLat cycles after accept
  always begin
    @(posedge clk);
    rstSeen = resetn;
    #1;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'hDEAD_BEEF;
    if (!rstSeen) begin
      pendResp = 0; prevAok = 0; reqCnt = 0; respCnt = 0;
    end else begin
      if (prevAok) begin pendResp = 1; respCnt = 0; end
      if (pendResp) begin
        respCnt++;
        if (respCnt >= dataLat) begin
          data_data_ok = 1'b1;
          data_rdata   = rdVal;
          pendResp     = 0;
        end
      end else if (data_req) begin
        reqCnt++;
        if (reqCnt >= addrLat) begin data_addr_ok = 1'b1; reqCnt = 0; end
      end else begin
        reqCnt = 0;
      end
      prevAok = data_addr_ok;
    end
  end

  // ---------------- directed stimulus ----------------
  int          sCnt;
  logic [31:0] sRd, sAddr, sWdata;
  logic [3:0]  sStrb;
  logic [1:0]  sSize;
  bit          sAdel, sAdes, sReq;

  // Present one access, count stall cycles, snapshot bus fields and result
  task automatic doOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                      input logic [31:0] r, input int aL, input int dL);
    @(posedge clk); #1;
    addrLat = aL; dataLat = dL; rdVal = r;
    memop_i = op; addr_i = a; wdata_i = w; mem_en_i = 1'b1;
    sCnt = 0; sReq = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_req) begin
        sReq = 1; sAddr = data_addr; sStrb = data_wstrb; sSize = data_size; sWdata = data_wdata;
      end
      sAdel = adel_o; sAdes = ades_o; sRd = rdata_o;
      if (!stall_o) break;
      sCnt++;
    end
    if (sCnt >= 60) begin
      nChecks++; nErrors++;
      $display("FAIL timeout: stall_o still high after %0d cycles, required low", sCnt);
    end
    @(posedge clk); #1;
    mem_en_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall_o", {31'b0, stall_o}, 32'h0);
    check("reset data_req", {31'b0, data_req}, 32'h0);
    check("reset rdata_o", rdata_o, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // SB / SH strobes and replication, 1-cycle bus
    doOp(MEMOP_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, 1);
    check("SB stall cycles", 32'(sCnt), 32'd3);
    check("SB wstrb", {28'b0, sStrb}, 32'h8);
    check("SB wdata", sWdata, 32'hA5A5_A5A5);
    check("SB size", {30'b0, sSize}, 32'd0);
    doOp(MEMOP_SH, 32'h0000_1002, 32'h0000_BEEF, 32'h0, 1, 1);
    check("SH wstrb", {28'b0, sStrb}, 32'hC);
    check("SH wdata", sWdata, 32'hBEEF_BEEF);

    // Byte loads, signed and unsigned
    doOp(MEMOP_LB, 32'h0000_2002, 32'h0, 32'h0080_0000, 1, 1);
    check("LB result", sRd, 32'hFFFF_FF80);
    doOp(MEMOP_LBU, 32'h0000_2002, 32'h0, 32'h0080_0000, 1, 1);
    check("LBU result", sRd, 32'h0000_0080);

    // Slow bus: 4 cycles to accept, 3 more to respond
    doOp(MEMOP_LH, 32'h0000_4002, 32'h0, 32'h8001_1234, 4, 3);
    check("slow stall cycles", 32'(sCnt), 32'd8);
    check("LH result", sRd, 32'hFFFF_8001);

    // Misaligned word load
    doOp(MEMOP_LW, 32'h0000_3002, 32'h0, 32'h1234_5678, 1, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misaligned LW adel", {31'b0, sAdel}, 32'h1);
    check("misaligned LW stall", 32'(sCnt), 32'd0);
    check("misaligned LW req seen", {31'b0, sReq}, 32'h0);
    check("misaligned LW rdata kept", sRd, 32'hFFFF_8001);
    doOp(MEMOP_SH, 32'h0000_5001, 32'h1, 32'h0, 1, 1);
    check("misaligned SH ades", {31'b0, sAdes}, 32'h1);
`else
    check("forced LW adel", {31'b0, sAdel}, 32'h0);
    check("forced LW addr", sAddr, 32'h0000_3000);
    check("forced LW stall", 32'(sCnt), 32'd3);
    check("forced LW result", sRd, 32'h1234_5678);
`endif

    // Flush during WAIT: result discarded, next request still launches
    doOp(MEMOP_LW, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 1, 1);
    check("LW before flush", sRd, 32'hCAFE_F00D);
    @(posedge clk); #1;
    addrLat = 1; dataLat = 3; rdVal = 32'h1111_1111; pipe_stall_i = 1'b1;
    memop_i = MEMOP_LW; addr_i = 32'h0000_6004; mem_en_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; memop_i = MEMOP_SW; addr_i = 32'h0000_6008; wdata_i = 32'h5A5A_5A5A;
    @(negedge clk);
    @(negedge clk);
    check("flush drain stall", {31'b0, stall_o}, 32'h1);
    @(negedge clk);
    check("post-flush new stall", {31'b0, stall_o}, 32'h1);
    check("post-flush rdata kept", rdata_o, 32'hCAFE_F00D);
    @(negedge clk);
    check("post-flush req", {31'b0, data_req}, 32'h1);
    check("post-flush addr", data_addr, 32'h0000_6008);
    for (int i = 0; i < 20 && stall_o; i++) @(negedge clk);
    check("SW done stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    mem_en_i = 1'b0; pipe_stall_i = 1'b0;
    @(posedge clk); #1;

    // DONE held by downstream stall
    pipe_stall_i = 1'b1;
    doOp(MEMOP_LW, 32'h0000_7000, 32'h0, 32'h89AB_CDEF, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold stall_o", {31'b0, stall_o}, 32'h0);
      check("hold rdata_o", rdata_o, 32'h89AB_CDEF);
    end
    @(posedge clk); #1;
    pipe_stall_i = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of REQ
    addrLat = 5; dataLat = 1;
    memop_i = MEMOP_LW; addr_i = 32'h0000_8000; mem_en_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-reset req", {31'b0, data_req}, 32'h1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; mem_en_i = 1'b0;
    @(negedge clk);
    check("post-reset req", {31'b0, data_req}, 32'h0);
    check("post-reset rdata", rdata_o, 32'h0);

    // Normal access after reset
    doOp(MEMOP_LHU, 32'h0000_9002, 32'h0, 32'hFFFE_0000, 1, 1);
    check("LHU result", sRd, 32'h0000_FFFE);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
